// File: rtl/rise_event_monitor.sv
// rise_event_monitor: windowed and lifetime counts of detector pulses, with a req/ack alarm on busy windows.
// Define MON_PEAK_TRACK_EN to build the peak closed-window register; otherwise peak_count is tied to 0.
module rise_event_monitor #(
   parameter int CNT_W   = 8,
   parameter int WIN_LEN = 16,
   parameter int THRESH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det,
   input  logic             clr,
   input  logic             alarm_ack,
   output logic [CNT_W-1:0] total_count,
   output logic [CNT_W-1:0] win_count,
   output logic             alarm_req,
   output logic             sat,
   output logic             overrun,
   output logic [CNT_W-1:0] peak_count
);
   localparam int TMR_W = $clog2(WIN_LEN);
   typedef enum logic [1:0] {RUN, REQ, DROP} state_t;
   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] win_q, win_d, tot_q, tot_d, win_inc, tot_inc;
   logic             sat_q, sat_d, ovr_q, ovr_d, req_q, req_d, close, qual;
   // win_inc doubles as the closing window's value, so a det on the close cycle counts there
   always_comb begin
      close   = tmr_q == TMR_W'(WIN_LEN - 1);
      win_inc = &win_q ? win_q : win_q + CNT_W'(det);
      tot_inc = &tot_q ? tot_q : tot_q + CNT_W'(det);
      qual    = close && win_inc >= CNT_W'(THRESH);
      tmr_d   = (clr || close) ? '0 : tmr_q + TMR_W'(1);
      win_d   = (clr || close) ? '0 : win_inc;
      tot_d   = clr ? '0 : tot_inc;
      sat_d   = !clr && (sat_q || &tot_inc);
      ovr_d   = !clr && (ovr_q || (qual && state_q != RUN));
      state_d = clr ? RUN :
                state_q == RUN ? (qual ? REQ : RUN) :
                state_q == REQ ? (alarm_ack ? DROP : REQ) :
                (alarm_ack ? DROP : RUN);
      req_d   = state_d == REQ;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         tmr_q   <= '0;
         win_q   <= '0;
         tot_q   <= '0;
         sat_q   <= 1'b0;
         ovr_q   <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         win_q   <= win_d;
         tot_q   <= tot_d;
         sat_q   <= sat_d;
         ovr_q   <= ovr_d;
         req_q   <= req_d;
      end
   end
`ifdef MON_PEAK_TRACK_EN
   logic [CNT_W-1:0] peak_q, peak_d;
   always_comb peak_d = clr ? '0 : (close && win_inc > peak_q) ? win_inc : peak_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) peak_q <= '0;
      else      peak_q <= peak_d;
   end
   assign peak_count = peak_q;
`else
   assign peak_count = '0;
`endif
   assign total_count = tot_q;
   assign win_count   = win_q;
   assign alarm_req   = req_q;
   assign sat         = sat_q;
   assign overrun     = ovr_q;
endmodule

// File: tb/tb_rise_event_monitor.sv
// tb_rise_event_monitor: directed and random stimulus for rise_event_monitor against an integer reference model.
module tb_rise_event_monitor;
   logic       clk = 0, rst = 0, det = 0, clr = 0, alarm_ack = 0;
   logic [7:0] total_count, win_count, peak_count;
   logic       alarm_req, sat, overrun;
   int         n_assert = 0, n_fail = 0;
   // reference state: window position, counts, and handshake phase (0 idle, 1 requesting, 2 awaiting ack low)
   int         m_pos, m_win, m_tot, m_peak, m_ph;
   bit         m_sat, m_ovr;

   rise_event_monitor #(.CNT_W(8), .WIN_LEN(16), .THRESH(4)) dut (
      .clk(clk), .rst(rst), .det(det), .clr(clr), .alarm_ack(alarm_ack),
      .total_count(total_count), .win_count(win_count), .alarm_req(alarm_req),
      .sat(sat), .overrun(overrun), .peak_count(peak_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_win = 0; m_tot = 0; m_peak = 0; m_ph = 0; m_sat = 0; m_ovr = 0;
   endtask

   task automatic check_all();
      chk("total_count", total_count, m_tot);
      chk("win_count", win_count, m_win);
      chk("alarm_req", alarm_req, m_ph == 1);
      chk("sat", sat, m_sat);
      chk("overrun", overrun, m_ovr);
`ifdef MON_PEAK_TRACK_EN
      chk("peak_count", peak_count, m_peak);
`else
      chk("peak_count", peak_count, 0);
`endif
   endtask

   task automatic step(input bit d, input bit c, input bit a);
      int w, ph;
      det = d; clr = c; alarm_ack = a;
      @(posedge clk);
      if (c) model_reset();
      else begin
         w = (m_win + d > 255) ? 255 : m_win + d;
         m_tot = (m_tot + d > 255) ? 255 : m_tot + d;
         if (m_tot == 255) m_sat = 1;
         ph = (m_ph == 0) ? 0 : (m_ph == 1) ? (a ? 2 : 1) : (a ? 2 : 0);
         if (m_pos == 15) begin
            if (w >= 4) begin
               if (m_ph == 0) ph = 1;
               else m_ovr = 1;
            end
            if (w > m_peak) m_peak = w;
            m_win = 0;
         end else m_win = w;
         m_ph = ph;
         m_pos = (m_pos + 1) % 16;
      end
      #1;
      check_all();
   endtask

   task automatic align();
      while (m_pos != 0) step(0, 0, 0);
   endtask

   task automatic window(input logic [15:0] m, input bit a);
      for (int i = 0; i < 16; i++) step(m[i], 0, a);
   endtask

   task automatic handshake();
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
   endtask

   initial begin
      model_reset();
      #12;
      check_all();
      rst = 1;
      for (int i = 0; i < 40; i++) step(0, 0, 0);
      align();
      window(16'h8224, 0);
      chk("req_after_close", alarm_req, 1);
      chk("win_zero_at_req", win_count, 0);
      handshake();
      chk("req_dropped", alarm_req, 0);
      align();
      window(16'h0124, 0);
      step(0, 0, 0);
      chk("no_alarm_3", alarm_req, 0);
      align();
      window(16'h8224, 0);
      window(16'h1115, 0);
      chk("overrun_set", overrun, 1);
      chk("single_req", alarm_req, 1);
      handshake();
      for (int i = 0; i < 260; i++) step(1, 0, 0);
      chk("sat_total", total_count, 255);
      chk("sat_flag", sat, 1);
      step(1, 1, 0);
      chk("clr_total", total_count, 0);
      chk("clr_req", alarm_req, 0);
      step(0, 0, 0);
      align();
      window(16'h0101, 0);
      window(16'h003F, 0);
      handshake();
      window(16'h0700, 0);
`ifdef MON_PEAK_TRACK_EN
      chk("peak_six", peak_count, 6);
`else
      chk("peak_tied", peak_count, 0);
`endif
      align();
      window(16'h003F, 0);
      chk("req_before_abort", alarm_req, 1);
      rst = 0;
      #1;
      model_reset();
      chk("abort_req", alarm_req, 0);
      chk("abort_total", total_count, 0);
      #3 rst = 1;
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
